// File: rtl/mxint_quant_pkg.sv
// Shared types and helpers for the MXINT stream quantizer.
package mxint_quant_pkg;

  typedef enum logic {
    COLLECT,
    EMIT
  } state_t;

  // Bits needed to index n distinct positions (at least one bit).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mxint_msb_detect.sv
// Combinational most-significant-set-bit finder with an all-zero flag.
module mxint_msb_detect
  import mxint_quant_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0]               value,
  output logic [idx_width(WIDTH)-1:0]    msb,
  output logic                           zero
);

  localparam int IW = idx_width(WIDTH);

  always_comb begin
    msb = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) msb = IW'(i);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/mxint_stream_quantizer.sv
// Streams a block of N fixed-point elements in, then streams out MXINT mantissas with a shared exponent.
// Define MXINT_QUANT_ROUND_EN for round-half-up on right shifts; otherwise right shifts truncate.
module mxint_stream_quantizer
  import mxint_quant_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0  = 8,
  parameter int DATA_IN_0_PRECISION_1  = 4,
  parameter int DATA_OUT_0_PRECISION_0 = 4,
  parameter int DATA_OUT_0_PRECISION_1 = 8,
  parameter int DATA_IN_0_DIM          = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] mdata_out_0 [0:0],
  output logic [DATA_OUT_0_PRECISION_1-1:0] edata_out_0,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int F  = DATA_IN_0_PRECISION_1;
  localparam int M  = DATA_OUT_0_PRECISION_0;
  localparam int E  = DATA_OUT_0_PRECISION_1;
  localparam int N  = DATA_IN_0_DIM;
  localparam int CW = idx_width(N);
  localparam int PW = idx_width(W + 1);
  localparam int XW = W + M + 1;
  localparam logic signed [XW-1:0] MANT_MAX = XW'((1 <<< (M - 1)) - 1);
  localparam logic signed [XW-1:0] MANT_MIN = XW'(-(1 <<< (M - 1)));

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W:0]     max_mag;
  logic [W:0]     mag;
  logic [W:0]     max_next;
  logic [W:0]     x_ext;
  logic [W-1:0]   store [N];
  logic [PW-1:0]  msb;
  logic           zero;
  logic           in_fire;
  logic           out_fire;
  logic [CW-1:0]  next_idx;
  logic [M-1:0]   mant_next;
  logic [E-1:0]   exp_next;

  function automatic logic [M-1:0] quantize(input logic [W-1:0] x, input logic [PW-1:0] p);
    logic signed [XW-1:0] v;
    int s;
    s = int'(p) - (M - 2);
    v = {{(XW - W){x[W-1]}}, x};
    if (s >= 0) begin
`ifdef MXINT_QUANT_ROUND_EN
      if (s > 0) v = v + (XW'(1) <<< (s - 1));
`endif
      v = v >>> s;
    end else begin
      v = v <<< (-s);
    end
    if (v > MANT_MAX)      quantize = MANT_MAX[M-1:0];
    else if (v < MANT_MIN) quantize = MANT_MIN[M-1:0];
    else                   quantize = v[M-1:0];
  endfunction

  assign in_fire  = data_in_0_valid && data_in_0_ready;
  assign out_fire = data_out_0_valid && data_out_0_ready;

  // Magnitude is one bit wider so that the most negative input is representable.
  always_comb begin
    x_ext    = {data_in_0[W-1], data_in_0};
    mag      = data_in_0[W-1] ? (~x_ext + 1'b1) : x_ext;
    max_next = (in_fire && (mag > max_mag)) ? mag : max_mag;
  end

  mxint_msb_detect #(.WIDTH(W + 1)) u_msb (
    .value (max_next),
    .msb   (msb),
    .zero  (zero)
  );

  // Element 0 is quantized on the last accept, later elements on each output handshake.
  always_comb begin
    next_idx  = (state == EMIT && cnt != CW'(N - 1)) ? cnt + CW'(1) : '0;
    mant_next = zero ? '0 : quantize(store[next_idx], msb);
    exp_next  = zero ? '0 : E'(int'(msb) - F);
  end

  always_ff @(posedge clk) begin
    if (in_fire) store[cnt] <= data_in_0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= COLLECT;
      cnt              <= '0;
      max_mag          <= '0;
      data_in_0_ready  <= 1'b0;
      data_out_0_valid <= 1'b0;
      mdata_out_0[0]   <= '0;
      edata_out_0      <= '0;
    end else begin
      case (state)
        COLLECT: begin
          data_in_0_ready <= 1'b1;
          if (in_fire) begin
            max_mag <= max_next;
            if (cnt == CW'(N - 1)) begin
              cnt              <= '0;
              state            <= EMIT;
              data_in_0_ready  <= 1'b0;
              data_out_0_valid <= 1'b1;
              mdata_out_0[0]   <= mant_next;
              edata_out_0      <= exp_next;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (cnt == CW'(N - 1)) begin
              cnt              <= '0;
              max_mag          <= '0;
              state            <= COLLECT;
              data_out_0_valid <= 1'b0;
              data_in_0_ready  <= 1'b1;
            end else begin
              cnt            <= cnt + CW'(1);
              mdata_out_0[0] <= mant_next;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/mxint_stream_quantizer.md
MXINT_STREAM_QUANTIZER -- requirements
Module: mxint_stream_quantizer

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 8, signed fixed-point input width W.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 4, input fraction width F.
REQ-003 SHALL have parameter DATA_OUT_0_PRECISION_0, default 4, signed mantissa width M; value = mant * 2^(exp-(M-2)).
REQ-004 SHALL have parameter DATA_OUT_0_PRECISION_1, default 8, signed two's-complement shared exponent width E.
REQ-005 SHALL have parameter DATA_IN_0_DIM, default 4, elements per block N (N >= 2).
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port data_in_0, input, W, one fixed-point element per beat.
REQ-009 SHALL have ports data_in_0_valid (input, 1) and data_in_0_ready (output, 1), input handshake.
REQ-010 SHALL have port mdata_out_0, output, unpacked [0:0] of M, one mantissa per beat.
REQ-011 SHALL have port edata_out_0, output, E, shared block exponent, constant for all N beats of a block.
REQ-012 SHALL have ports data_out_0_valid (output, 1) and data_out_0_ready (input, 1), output handshake.

Function
REQ-013 SHALL implement FSM states COLLECT and EMIT; reset state COLLECT.
REQ-014 In COLLECT: data_in_0_ready=1, data_out_0_valid=0; each handshake stores element at index cnt and increments cnt.
REQ-015 SHALL track running max magnitude |x| during COLLECT (|-2^(W-1)| = 2^(W-1), computed in W+1 bits).
REQ-016 On the accept of element N-1: cnt wraps to 0, state -> EMIT; exponent and first mantissa valid next cycle (latency 1 cycle after last input accept).
REQ-017 Exponent: p = MSB index of max magnitude; exp = p - F, sign-extended to E bits; all-zero block -> exp = 0, all mantissas 0.
REQ-018 Mantissa: shift s = p-(M-2); s >= 0 -> arithmetic right shift by s; s < 0 -> left shift by -s; result saturated to [-2^(M-1), 2^(M-1)-1].
REQ-019 In EMIT: data_in_0_ready=0; data_out_0_valid=1; outputs held stable while data_out_0_ready=0.
REQ-020 On output handshake of element N-1: cnt -> 0, running max cleared, state -> COLLECT; data_in_0_ready=1 next cycle.
REQ-021 Inputs arriving while in EMIT SHALL be back-pressured, never dropped or overwritten.
REQ-022 Elements SHALL emerge in arrival order, one per output handshake; no bubbles while data_out_0_ready=1.

Reset
REQ-023 Asserting rst (low) at any time, including mid-COLLECT or mid-EMIT, SHALL discard the partial block.
REQ-024 During reset: state COLLECT, cnt 0, max 0, data_out_0_valid 0, data_in_0_ready 0, mdata_out_0 0, edata_out_0 0.
REQ-025 First cycle after rst deasserts: data_in_0_ready 1.

Configuration
REQ-026 Macro MXINT_QUANT_ROUND_EN defined: when s > 0, add 2^(s-1) before right shift (round-half-up), then saturate.
REQ-027 Macro undefined: right shift truncates (floor); saturation still applied.

Structure
REQ-028 Package mxint_quant_pkg SHALL hold the FSM state enum and the MSB-index width constant function.
REQ-029 Sub-module mxint_msb_detect SHALL return MSB index of an unsigned vector plus zero flag, combinational.
REQ-030 Element storage SHALL be an N-entry register array; no FIFO IP.

Verification (W=8, F=4, M=4, E=8, N=4)
REQ-031 In 16,8,4,-16 -> exp 0x00, mant 4,2,1,-4 (0x4,0x2,0x1,0xC).
REQ-032 In 0,0,0,0 -> exp 0x00, mant 0,0,0,0.
REQ-033 In 1,0,0,-1 -> exp 0xFC (-4), mant 4,0,0,-4 (left shift 2).
REQ-034 In 16,6,3,0 -> ROUND_EN: mant 4,2,1,0; without: 4,1,0,0; in 127,0,0,0 with ROUND_EN -> exp 0x02, mant 7 (saturated).
REQ-035 data_out_0_ready low 3 cycles mid-EMIT -> outputs frozen, data_in_0_ready held 0, no element lost.
REQ-036 rst pulsed after 2nd output beat -> valid 0 immediately, ready 1 after release, next block starts at index 0.
